request_queue_unit: RTL and testbench

Parametrised two-channel request unit between the CPU datapath and the single-ported memory controller. It accepts instruction-fetch and data requests, buffers data stores in a DEPTH-entry posted-write FIFO, and forwards loads that hit a buffered store. It serialises all memory traffic onto one read/write port through a fixed-priority arbiter FSM. It extends the single-outstanding, unbuffered request unit with write posting, store-to-load forwarding and configurable widths and depth.

---
 rtl/request_queue_unit_pkg.sv | 19 +
 rtl/request_queue_unit_wb_fifo.sv | 71 +++++++
 rtl/request_queue_unit.sv | 147 ++++++++++++++
 tb/tb_request_queue_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/request_queue_unit_pkg.sv
// Shared types for the request queue unit: arbiter states and the posted-write entry layout.
package request_queue_unit_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    WDRAIN = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/request_queue_unit_wb_fifo.sv
// Posted-write circular buffer with a head port and a parallel youngest-match lookup for forwarding.
module wb_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        hit_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin : lookup
    logic [PTR_W-1:0] idx;
    idx      = rd_ptr;
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_mem[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/request_queue_unit.sv
// Two-channel request unit: posts stores into a write buffer, forwards hitting loads,
// and serialises fetches, load misses and buffer drains onto one memory port.
module request_queue_unit
  import request_queue_unit_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_req,
  input  logic [ADDR_W-1:0]      i_addr,
  output logic                   i_ack,
  output logic [DATA_W-1:0]      i_rdata,
  input  logic                   d_req,
  input  logic                   d_wen,
  input  logic [ADDR_W-1:0]      d_addr,
  input  logic [DATA_W-1:0]      d_wdata,
  output logic                   d_ack,
  output logic [DATA_W-1:0]      d_rdata,
  output logic                   m_ren,
  output logic                   m_wen,
  output logic [ADDR_W-1:0]      m_addr,
  output logic [DATA_W-1:0]      m_wdata,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] wb_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_state_t        state;
  logic              i_pend;
  logic              d_pend;
  logic              fifo_full;
  logic              fifo_empty;
  logic              store_acc;
  logic              load_hit;
  logic              load_miss;
  logic              pop;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  count;

  // A request seen while its own ack is high is the one just serviced.
  assign i_pend     = i_req & ~i_ack;
  assign d_pend     = d_req & ~d_ack;
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign store_acc  = d_pend & d_wen & ~fifo_full;
  assign load_hit   = d_pend & ~d_wen & hit;
  assign load_miss  = d_pend & ~d_wen & ~hit;
  assign pop        = (state == WDRAIN) & m_ready;
  assign wb_count   = count;

  wb_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_wb_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push        (store_acc),
    .push_addr   (d_addr),
    .push_data   (d_wdata),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .lookup_addr (d_addr),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  // A missing load may bypass buffered stores since none of them alias it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      m_ren   <= 1'b0;
      m_wen   <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (store_acc) d_ack <= 1'b1;
      if (load_hit) begin
        d_ack   <= 1'b1;
        d_rdata <= hit_data;
      end
      case (state)
        IDLE: begin
          if (load_miss) begin
            state  <= DREAD;
            m_ren  <= 1'b1;
            m_addr <= d_addr;
          end else if (fifo_full) begin
            state   <= WDRAIN;
            m_wen   <= 1'b1;
            m_addr  <= head_addr;
            m_wdata <= head_data;
          end else if (i_pend) begin
            state  <= IFETCH;
            m_ren  <= 1'b1;
            m_addr <= i_addr;
          end else if (!fifo_empty) begin
            state   <= WDRAIN;
            m_wen   <= 1'b1;
            m_addr  <= head_addr;
            m_wdata <= head_data;
          end
        end
        IFETCH: begin
          if (m_ready) begin
            state   <= IDLE;
            m_ren   <= 1'b0;
            i_ack   <= 1'b1;
            i_rdata <= m_rdata;
          end
        end
        DREAD: begin
          if (m_ready) begin
            state   <= IDLE;
            m_ren   <= 1'b0;
            d_ack   <= 1'b1;
            d_rdata <= m_rdata;
          end
        end
        WDRAIN: begin
          if (m_ready) begin
            state <= IDLE;
            m_wen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_request_queue_unit.sv
// Directed bench: cycle table for the main unit, hand sequences for full-buffer and DEPTH=2 wrap cases.
module tb_request_queue_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_req, d_req, d_wen, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_ack, d_ack, m_ren, m_wen;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [2:0]  wb_count;

  logic        RST2;
  logic        i_req2, d_req2, d_wen2, m_ready2;
  logic [31:0] i_addr2, d_addr2, d_wdata2, m_rdata2;
  logic        i_ack2, d_ack2, m_ren2, m_wen2;
  logic [31:0] i_rdata2, d_rdata2, m_addr2, m_wdata2;
  logic [1:0]  wb_count2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  request_queue_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) u_dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .wb_count(wb_count)
  );

  request_queue_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) u_dut2 (
    .CLK(CLK), .RST(RST2),
    .i_req(i_req2), .i_addr(i_addr2), .i_ack(i_ack2), .i_rdata(i_rdata2),
    .d_req(d_req2), .d_wen(d_wen2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_ack(d_ack2), .d_rdata(d_rdata2),
    .m_ren(m_ren2), .m_wen(m_wen2), .m_addr(m_addr2), .m_wdata(m_wdata2),
    .m_rdata(m_rdata2), .m_ready(m_ready2), .wb_count(wb_count2)
  );

  typedef struct {
    logic        rst, i_req;
    logic [31:0] i_addr;
    logic        d_req, d_wen;
    logic [31:0] d_addr, d_wdata, m_rdata;
    logic        m_ready;
    logic        e_iack, e_dack;
    logic [31:0] e_irdata, e_drdata;
    logic        e_mren, e_mwen;
    logic [31:0] e_maddr, e_mwdata;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(
    input logic rst, input logic ireq, input logic [31:0] iaddr,
    input logic dreq, input logic dwen, input logic [31:0] daddr, input logic [31:0] dwdata,
    input logic [31:0] mrdata, input logic mready,
    input logic eiack, input logic edack, input logic [31:0] eirdata, input logic [31:0] edrdata,
    input logic emren, input logic emwen, input logic [31:0] emaddr, input logic [31:0] emwdata,
    input logic [2:0] ecnt);
    vec_t v;
    v.rst = rst; v.i_req = ireq; v.i_addr = iaddr;
    v.d_req = dreq; v.d_wen = dwen; v.d_addr = daddr; v.d_wdata = dwdata;
    v.m_rdata = mrdata; v.m_ready = mready;
    v.e_iack = eiack; v.e_dack = edack; v.e_irdata = eirdata; v.e_drdata = edrdata;
    v.e_mren = emren; v.e_mwen = emwen; v.e_maddr = emaddr; v.e_mwdata = emwdata;
    v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    RST = v.rst; i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_wen = v.d_wen; d_addr = v.d_addr; d_wdata = v.d_wdata;
    m_rdata = v.m_rdata; m_ready = v.m_ready;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    cmp($sformatf("r%0d i_ack", idx), 32'(i_ack), 32'(v.e_iack));
    cmp($sformatf("r%0d d_ack", idx), 32'(d_ack), 32'(v.e_dack));
    cmp($sformatf("r%0d m_ren", idx), 32'(m_ren), 32'(v.e_mren));
    cmp($sformatf("r%0d m_wen", idx), 32'(m_wen), 32'(v.e_mwen));
    cmp($sformatf("r%0d wb_count", idx), 32'(wb_count), 32'(v.e_cnt));
    if (v.e_iack || v.rst)
      cmp($sformatf("r%0d i_rdata", idx), i_rdata, v.e_irdata);
    if ((v.e_dack && !v.d_wen) || v.rst)
      cmp($sformatf("r%0d d_rdata", idx), d_rdata, v.e_drdata);
    if (v.e_mren || v.e_mwen || v.rst)
      cmp($sformatf("r%0d m_addr", idx), m_addr, v.e_maddr);
    if (v.e_mwen || v.rst)
      cmp($sformatf("r%0d m_wdata", idx), m_wdata, v.e_mwdata);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k;
    int nwr;
    RST = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
    m_rdata = 0; m_ready = 0;
    RST2 = 1'b1; i_req2 = 0; i_addr2 = 0; d_req2 = 0; d_wen2 = 0; d_addr2 = 0; d_wdata2 = 0;
    m_rdata2 = 0; m_ready2 = 0;

    // rst ireq iaddr dreq dwen daddr dwdata mrdata mready | iack dack irdata drdata mren mwen maddr mwdata cnt
    tbl.push_back(row(1,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,0,0,0,          0));
    tbl.push_back(row(0,0,0,      1,1,'h200,'hAAAA,0,0,            0,1,0,0,               0,0,0,0,          1));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,1,'h200,'hAAAA, 1));
    tbl.push_back(row(0,0,0,      1,1,'h200,'hBBBB,0,0,            0,1,0,0,               0,1,'h200,'hAAAA, 2));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,1,'h200,'hAAAA, 2));
    tbl.push_back(row(0,0,0,      1,0,'h200,0,  0,0,               0,1,0,'hBBBB,          0,1,'h200,'hAAAA, 2));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,1,               0,0,0,0,               0,0,0,0,          1));
    tbl.push_back(row(0,0,0,      1,0,'h300,0,  0,0,               0,0,0,0,               1,0,'h300,0,      1));
    tbl.push_back(row(0,0,0,      1,0,'h300,0,  'h12345678,1,      0,1,0,'h12345678,      0,0,0,0,          1));
    tbl.push_back(row(0,0,0,      1,0,'h300,0,  0,0,               0,0,0,0,               0,1,'h200,'hBBBB, 1));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,1,               0,0,0,0,               0,0,0,0,          0));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,0,0,0,          0));
    tbl.push_back(row(0,1,'h80,   1,1,'h400,'h11,0,0,              0,1,0,0,               1,0,'h80,0,       1));
    tbl.push_back(row(0,1,'h80,   0,0,0,0,      0,0,               0,0,0,0,               1,0,'h80,0,       1));
    tbl.push_back(row(0,1,'h80,   1,1,'h404,'h22,0,0,              0,1,0,0,               1,0,'h80,0,       2));
    tbl.push_back(row(0,1,'h80,   0,0,0,0,      0,0,               0,0,0,0,               1,0,'h80,0,       2));
    tbl.push_back(row(0,1,'h80,   1,0,'h300,0,  'hCAFE,1,          1,0,'hCAFE,0,          0,0,0,0,          2));
    tbl.push_back(row(0,1,'h80,   1,0,'h300,0,  0,0,               0,0,0,0,               1,0,'h300,0,      2));
    tbl.push_back(row(0,0,0,      1,0,'h300,0,  'hBEEF,1,          0,1,0,'hBEEF,          0,0,0,0,          2));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,1,'h400,'h11,   2));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,1,               0,0,0,0,               0,0,0,0,          1));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,1,'h404,'h22,   1));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,1,               0,0,0,0,               0,0,0,0,          0));
    tbl.push_back(row(0,1,0,      1,0,'h40,0,   0,0,               0,0,0,0,               1,0,'h40,0,       0));
    tbl.push_back(row(0,1,0,      1,0,'h40,0,   0,0,               0,0,0,0,               1,0,'h40,0,       0));
    tbl.push_back(row(0,1,0,      1,0,'h40,0,   'h4444,1,          0,1,0,'h4444,          0,0,0,0,          0));
    tbl.push_back(row(0,1,0,      1,0,'h40,0,   0,0,               0,0,0,0,               1,0,0,0,          0));
    tbl.push_back(row(0,1,0,      0,0,0,0,      0,0,               0,0,0,0,               1,0,0,0,          0));
    tbl.push_back(row(0,1,0,      0,0,0,0,      'h5555,1,          1,0,'h5555,0,          0,0,0,0,          0));
    tbl.push_back(row(0,1,0,      0,0,0,0,      0,0,               0,0,0,0,               0,0,0,0,          0));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,0,0,0,          0));
    tbl.push_back(row(0,0,0,      1,1,'h500,1,  0,0,               0,1,0,0,               0,0,0,0,          1));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,1,'h500,1,      1));
    tbl.push_back(row(0,0,0,      1,1,'h504,2,  0,0,               0,1,0,0,               0,1,'h500,1,      2));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,1,'h500,1,      2));
    tbl.push_back(row(0,0,0,      1,1,'h508,3,  0,0,               0,1,0,0,               0,1,'h500,1,      3));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,1,'h500,1,      3));
    tbl.push_back(row(1,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,0,0,0,          0));
    tbl.push_back(row(0,0,0,      0,0,0,0,      0,0,               0,0,0,0,               0,0,0,0,          0));

    for (int r = 0; r < tbl.size(); r++) begin
      applyStimulus(tbl[r]);
      checkOutput(r, tbl[r]);
    end

    // Fill all four entries while the first drain stalls, then hold a fifth store.
    for (int s = 0; s < 4; s++) begin
      vec_t v;
      v = row(0,0,0, 1,1,32'h100 + 32'(s*4),32'hD0 + 32'(s), 0,0,
              0,1,0,0, 0,(s != 0),'h100,'hD0, 3'(s+1));
      applyStimulus(v);
      checkOutput(100 + 2*s, v);
      v = row(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,1,'h100,'hD0, 3'(s+1));
      applyStimulus(v);
      checkOutput(101 + 2*s, v);
    end
    for (int s = 0; s < 3; s++) begin
      vec_t v;
      v = row(0,0,0, 1,1,'h110,'hE0, 0,0, 0,0,0,0, 0,1,'h100,'hD0, 4);
      applyStimulus(v);
      checkOutput(110 + s, v);
    end
    begin
      vec_t v;
      v = row(0,0,0, 1,1,'h110,'hE0, 0,1, 0,0,0,0, 0,0,0,0, 3);
      applyStimulus(v);
      checkOutput(120, v);
      v = row(0,0,0, 1,1,'h110,'hE0, 0,0, 0,1,0,0, 0,1,'h104,'hD1, 4);
      applyStimulus(v);
      checkOutput(121, v);
      v = row(0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,1,'h104,'hD1, 4);
      applyStimulus(v);
      checkOutput(122, v);
    end

    // DEPTH=2 unit: ten stores against a randomly stalling memory must drain in order.
    @(negedge CLK);
    RST2 = 1'b0;
    k = 0;
    nwr = 0;
    d_req2 = 1'b1; d_wen2 = 1'b1;
    d_addr2 = 32'h1000; d_wdata2 = 32'h7;
    for (int cyc = 0; cyc < 600 && nwr < 10; cyc++) begin
      @(negedge CLK);
      if (d_ack2) begin
        k++;
        if (k < 10) begin
          d_addr2  = 32'h1000 + 32'(k*4);
          d_wdata2 = 32'(k*'h111 + 7);
        end else begin
          d_req2 = 1'b0;
        end
      end
      m_ready2 = 1'($urandom_range(0, 1));
      if (m_wen2 && m_ready2) begin
        cmp($sformatf("d2 wr%0d addr", nwr), m_addr2, 32'h1000 + 32'(nwr*4));
        cmp($sformatf("d2 wr%0d data", nwr), m_wdata2, 32'(nwr*'h111 + 7));
        nwr++;
      end
    end
    cmp("d2 writes", 32'(nwr), 32'd10);
    cmp("d2 stores", 32'(k), 32'd10);
    @(negedge CLK);
    m_ready2 = 1'b0;
    cmp("d2 final count", 32'(wb_count2), 32'd0);
    cmp("d2 final m_wen", 32'(m_wen2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
